mini_cnn_window_feeder: RTL and testbench

Upstream stage of the mini CNN processing element. Accepts a row-major pixel stream over a valid/ready handshake and builds 3x3 windows using two line buffers. For every complete window it serially drives the PE with 9 window pixels, then 9 kernel weights, holding `pe_start` high for 18 cycles. It then stalls the stream until the PE asserts `done`, and repeats. Kernel weights are held in a local 9-entry register file written by the host.

---
 rtl/mini_cnn_window_feeder_if.sv | 12 +
 rtl/mini_cnn_window_feeder.sv | 157 +++++++++++++++
 tb/tb_mini_cnn_window_feeder.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_cnn_window_feeder_if.sv
// Pixel stream handshake between the upstream source and the window feeder.
interface mini_cnn_window_feeder_if #(
    parameter int DATA_W = 8
) ();
    logic                     pix_valid;
    logic                     pix_sof;
    logic signed [DATA_W-1:0] pix_data;
    logic                     pix_ready;

    modport master (output pix_valid, output pix_sof, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_sof, input pix_data, output pix_ready);
endinterface

// File: rtl/mini_cnn_window_feeder.sv
// Builds 3x3 windows from a row-major pixel stream and serially feeds each window
// followed by the kernel weights to the processing element.
module mini_cnn_window_feeder #(
    parameter int IMG_W    = 8,
    parameter int DATA_W   = 8,
    parameter int WIN_SIZE = 9,
    parameter int POS_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     k_we,
    input  logic [3:0]               k_addr,
    input  logic signed [DATA_W-1:0] k_data,
    mini_cnn_window_feeder_if.slave  pix,
    output logic signed [DATA_W-1:0] pe_data,
    output logic                     pe_start,
    input  logic                     pe_done,
    output logic [POS_W-1:0]         win_row,
    output logic [POS_W-1:0]         win_col,
    output logic [POS_W-1:0]         win_count,
    output logic                     busy
);
    localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [4:0] LAST_IDX = 5'(2 * WIN_SIZE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]               state;
    logic [4:0]               idx;
    logic [4:0]               nidx;
    logic [POS_W-1:0]         row;
    logic [POS_W-1:0]         col;
    logic [POS_W-1:0]         next_row;
    logic [POS_W-1:0]         next_col;
    logic [LB_AW-1:0]         lb_idx;
    logic                     accept;
    logic                     complete;
    logic signed [DATA_W-1:0] next_val;

    logic signed [DATA_W-1:0] lb0   [0:IMG_W-1];
    logic signed [DATA_W-1:0] lb1   [0:IMG_W-1];
    logic signed [DATA_W-1:0] col_a [0:2];
    logic signed [DATA_W-1:0] col_b [0:2];
    logic signed [DATA_W-1:0] new_col [0:2];
    logic signed [DATA_W-1:0] sbuf  [0:WIN_SIZE-1];
    logic signed [DATA_W-1:0] kern  [0:8];

    // Position of the pixel being offered and the column entering the window.
    always_comb begin
        accept = (state == IDLE) && pix.pix_ready && pix.pix_valid;
        if (pix.pix_sof) begin
            next_row = '0;
            next_col = '0;
        end else if (col == POS_W'(IMG_W - 1)) begin
            next_row = row + POS_W'(1);
            next_col = '0;
        end else begin
            next_row = row;
            next_col = col + POS_W'(1);
        end
        lb_idx     = next_col[LB_AW-1:0];
        complete   = accept && (next_row >= POS_W'(2)) && (next_col >= POS_W'(2));
        new_col[0] = lb0[lb_idx];
        new_col[1] = lb1[lb_idx];
        new_col[2] = pix.pix_data;
        nidx       = idx + 5'd1;
        if (nidx < 5'(WIN_SIZE)) begin
            next_val = sbuf[nidx[3:0]];
        end else begin
            next_val = kern[4'(nidx - 5'(WIN_SIZE))];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[lb_idx] <= lb1[lb_idx];
            lb1[lb_idx] <= pix.pix_data;
            for (int r = 0; r < 3; r++) begin
                col_a[r] <= col_b[r];
                col_b[r] <= new_col[r];
            end
        end
        if (complete) begin
            for (int r = 0; r < 3; r++) begin
                sbuf[r*3]     <= col_a[r];
                sbuf[r*3 + 1] <= col_b[r];
                sbuf[r*3 + 2] <= new_col[r];
            end
        end
    end

    // Kernel writes land only in IDLE so the weights stay frozen for the window in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            row           <= '0;
            col           <= '0;
            pix.pix_ready <= 1'b0;
            pe_start      <= 1'b0;
            pe_data       <= '0;
            win_row       <= '0;
            win_col       <= '0;
            win_count     <= '0;
            busy          <= 1'b0;
            for (int k = 0; k < 9; k++) kern[k] <= '0;
        end else begin
            if ((state == IDLE) && k_we && (k_addr < 4'd9)) kern[k_addr] <= k_data;
            case (state)
                IDLE: begin
                    pix.pix_ready <= 1'b1;
                    if (accept) begin
                        row <= next_row;
                        col <= next_col;
                        if (pix.pix_sof) win_count <= '0;
                        if (complete) begin
                            state         <= SEND;
                            idx           <= '0;
                            pe_start      <= 1'b1;
                            pe_data       <= col_a[0];
                            win_row       <= next_row - POS_W'(2);
                            win_col       <= next_col - POS_W'(2);
                            win_count     <= win_count + POS_W'(1);
                            busy          <= 1'b1;
                            pix.pix_ready <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (idx == LAST_IDX) begin
                        state    <= WAIT;
                        pe_start <= 1'b0;
                        pe_data  <= '0;
                    end else begin
                        idx     <= nidx;
                        pe_data <= next_val;
                    end
                end
                WAIT: begin
                    if (pe_done) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        pix.pix_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    pe_start <= 1'b0;
                    pe_data  <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mini_cnn_window_feeder.sv
// Randomized bench for the window feeder: a frame-level model predicts every
// 18-beat stream, its position tags and the handshake stall timing.
module tb_mini_cnn_window_feeder;
    localparam int IMG_W  = 4;
    localparam int DATA_W = 8;
    localparam int POS_W  = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     k_we;
    logic [3:0]               k_addr;
    logic signed [DATA_W-1:0] k_data;
    logic signed [DATA_W-1:0] pe_data;
    logic                     pe_start;
    logic                     pe_done;
    logic [POS_W-1:0]         win_row;
    logic [POS_W-1:0]         win_col;
    logic [POS_W-1:0]         win_count;
    logic                     busy;

    mini_cnn_window_feeder_if #(.DATA_W(DATA_W)) pix_if ();

    mini_cnn_window_feeder #(
        .IMG_W(IMG_W), .DATA_W(DATA_W), .WIN_SIZE(9), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .pix(pix_if), .pe_data(pe_data), .pe_start(pe_start), .pe_done(pe_done),
        .win_row(win_row), .win_col(win_col), .win_count(win_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected streams, one entry per predicted window.
    int exp_vals[$];
    int exp_row[$];
    int exp_col[$];
    int exp_cnt[$];
    int exp_cyc[$];

    int m_kern[9];
    int img[0:63][0:IMG_W-1];
    int m_row = 0;
    int m_col = 0;
    int m_count = 0;
    bit stall_pending = 0;
    int done_edge_cyc = 0;
    int done_delay = 3;
    bit cap_active = 0;
    int cap_idx = 0;
    int done_countdown = 0;
    bit pend_we = 0;
    int pend_addr = 0;
    int pend_data = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 9; k++) m_kern[k] = 0;
        m_row = 0;
        m_col = 0;
        m_count = 0;
        stall_pending = 0;
        pend_we = 0;
    endtask

    // One accepted pixel at frame level: place it, and if it closes a 3x3 patch, predict the stream.
    task automatic modelAccept(input int val, input bit sof);
        if (sof) begin
            m_row = 0;
            m_col = 0;
            m_count = 0;
        end else if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
        img[m_row & 63][m_col] = val;
        if (pend_we && pend_addr < 9) m_kern[pend_addr] = pend_data;
        if (m_row >= 2 && m_col >= 2) begin
            m_count++;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp_vals.push_back(img[(m_row - 2 + i) & 63][m_col - 2 + j]);
            for (int k = 0; k < 9; k++) exp_vals.push_back(m_kern[k]);
            exp_row.push_back(m_row - 2);
            exp_col.push_back(m_col - 2);
            exp_cnt.push_back(m_count);
            exp_cyc.push_back(cyc);
            stall_pending = 1;
        end
    endtask

    task automatic applyStimulus(input int val, input bit sof, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_sof   = sof;
        pix_if.pix_data  = val[7:0];
        k_we   = pend_we;
        k_addr = pend_addr[3:0];
        k_data = pend_data[7:0];
        waited = 0;
        while (!pix_if.pix_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!pix_if.pix_ready) begin
            checkOutput("ready_timeout", 0, 1);
            pix_if.pix_valid = 1'b0;
            k_we = 1'b0;
            pend_we = 0;
            return;
        end
        if (stall_pending) begin
            checkOutput("ready_after_done", cyc, done_edge_cyc);
            stall_pending = 0;
        end else begin
            checkOutput("ready_idle", waited, 0);
        end
        @(posedge clk);
        #1;
        modelAccept(val, sof);
        pix_if.pix_valid = 1'b0;
        pix_if.pix_sof   = 1'b0;
        k_we = 1'b0;
        pend_we = 0;
    endtask

    task automatic writeKernel(input int addr, input int data);
        @(negedge clk);
        k_we = 1'b1;
        k_addr = addr[3:0];
        k_data = data[7:0];
        @(posedge clk);
        #1;
        if (addr < 9) m_kern[addr] = data;
        k_we = 1'b0;
    endtask

    task automatic sendFrame(input int rows, input int maxgap);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IMG_W; c++)
                applyStimulus(int'($urandom_range(0, 255)) - 128, (r == 0 && c == 0),
                              int'($urandom_range(0, maxgap)));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_cnt.size() != 0 || cap_active || done_countdown != 0 || pe_done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) checkOutput("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        stall_pending = 0;
    endtask

    // PE model and stream checker.
    initial begin
        int tag_row, tag_col, tag_cnt, tag_cyc;
        pe_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap_active = 0;
                cap_idx = 0;
                done_countdown = 0;
                pe_done = 1'b0;
                exp_vals.delete();
                exp_row.delete();
                exp_col.delete();
                exp_cnt.delete();
                exp_cyc.delete();
                continue;
            end
            if (pe_done) pe_done = 1'b0;
            if (done_countdown > 0) begin
                done_countdown--;
                if (done_countdown == 0) begin
                    pe_done = 1'b1;
                    done_edge_cyc = cyc + 1;
                end
            end
            if (!cap_active) begin
                if (pe_start) begin
                    if (exp_cnt.size() == 0) begin
                        checkOutput("unexpected_start", 1, 0);
                    end else begin
                        tag_row = exp_row.pop_front();
                        tag_col = exp_col.pop_front();
                        tag_cnt = exp_cnt.pop_front();
                        tag_cyc = exp_cyc.pop_front();
                        checkOutput("start_cycle", cyc, tag_cyc);
                        checkOutput("win_row", int'(win_row), tag_row);
                        checkOutput("win_col", int'(win_col), tag_col);
                        checkOutput("win_count", int'(win_count), tag_cnt);
                        checkOutput("busy_send", int'(busy), 1);
                        checkOutput("pe_data[0]", int'(pe_data), exp_vals.pop_front());
                        cap_active = 1;
                        cap_idx = 1;
                    end
                end
            end else if (cap_idx < 18) begin
                checkOutput("start_held", int'(pe_start), 1);
                checkOutput($sformatf("pe_data[%0d]", cap_idx), int'(pe_data),
                            (exp_vals.size() != 0) ? exp_vals.pop_front() : 9999);
                cap_idx++;
            end else begin
                checkOutput("start_fall", int'(pe_start), 0);
                checkOutput("pe_data_wait", int'(pe_data), 0);
                checkOutput("busy_wait", int'(busy), 1);
                cap_active = 0;
                cap_idx = 0;
                done_countdown = done_delay;
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        k_we = 1'b0;
        k_addr = '0;
        k_data = '0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_sof = 1'b0;
        pix_if.pix_data = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", int'(pix_if.pix_ready), 0);
        checkOutput("rst_start", int'(pe_start), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_count", int'(win_count), 0);
        checkOutput("rst_data", int'(pe_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", int'(pix_if.pix_ready), 0);
        @(negedge clk);
        checkOutput("ready_up", int'(pix_if.pix_ready), 1);

        $display("[TB] kernel load and 4x4 frame of 1..16");
        for (int i = 0; i < 9; i++) writeKernel(i, i + 1);
        writeKernel(12, 99);
        for (int p = 1; p <= 16; p++) applyStimulus(p, (p == 1), 0);
        waitDrain();
        checkOutput("frame_count", int'(win_count), 4);
        checkOutput("idle_busy", int'(busy), 0);

        $display("[TB] backpressure with slow PE");
        done_delay = 50;
        sendFrame(3, 0);
        waitDrain();
        done_delay = 3;

        $display("[TB] kernel freeze");
        for (int p = 0; p < 11; p++)
            applyStimulus(int'($urandom_range(0, 255)) - 128, (p == 0), 0);
        k_we = 1'b1;
        k_addr = 4'd4;
        k_data = -8'sd7;
        @(posedge clk);
        #1 k_we = 1'b0;
        applyStimulus(int'($urandom_range(0, 255)) - 128, 1'b0, 0);
        pend_we = 1; pend_addr = 4; pend_data = -7;
        applyStimulus(int'($urandom_range(0, 255)) - 128, 1'b0, 0);
        applyStimulus(int'($urandom_range(0, 255)) - 128, 1'b0, 0);
        pend_we = 1; pend_addr = 0; pend_data = 5;
        applyStimulus(int'($urandom_range(0, 255)) - 128, 1'b0, 0);
        applyStimulus(int'($urandom_range(0, 255)) - 128, 1'b0, 0);
        waitDrain();

        $display("[TB] mid-frame restart");
        for (int p = 0; p < 6; p++)
            applyStimulus(int'($urandom_range(0, 255)) - 128, (p == 0), 0);
        sendFrame(4, 2);
        waitDrain();
        checkOutput("restart_count", int'(win_count), 4);

        $display("[TB] random frames");
        repeat (3) sendFrame(int'($urandom_range(3, 5)), 3);
        waitDrain();

        $display("[TB] reset during SEND");
        for (int p = 0; p < 11; p++)
            applyStimulus(int'($urandom_range(0, 255)) - 128, (p == 0), 0);
        n = 0;
        while (!(cap_active && cap_idx == 5) && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reach_idx5", int'(n < 100), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_start", int'(pe_start), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_ready", int'(pix_if.pix_ready), 0);
        checkOutput("abort_data", int'(pe_data), 0);
        checkOutput("abort_count", int'(win_count), 0);
        checkOutput("abort_row", int'(win_row), 0);
        checkOutput("abort_col", int'(win_col), 0);
        #1 rst = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("abort_ready_up", int'(pix_if.pix_ready), 1);
        checkOutput("abort_still_idle", int'(pe_start), 0);

        $display("[TB] recovery frame with cleared kernel");
        sendFrame(3, 1);
        waitDrain();
        checkOutput("recover_count", int'(win_count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
